fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_W, 8, program counter / instruction memory address width.
REQ-002 Parameter TIMEOUT, 15, max WAIT cycles without mem_ack before abort; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 fetch  input  1  control-unit request to fetch the instruction at pc; level-sampled.
REQ-006 jmp_en  input  1  load pc from jmp_addr (taken jump, call, ret).
REQ-007 jmp_addr  input  PC_W  jump target.
REQ-008 mem_req  output  1  registered read request to instruction memory.
REQ-009 mem_addr  output  PC_W  registered read address; valid while mem_req=1.
REQ-010 mem_ack  input  1  memory asserts for one cycle with mem_rdata valid.
REQ-011 mem_rdata  input  16  instruction word.
REQ-012 ir  output  16  instruction register.
REQ-013 opcode  output  5  ir[15:11], combinational from ir; drives control-unit opcode input.
REQ-014 pc  output  PC_W  address of next instruction to fetch.
REQ-015 ir_valid  output  1  ir holds a freshly fetched word.
REQ-016 busy  output  1  high while in WAIT.
REQ-017 fetch_err  output  1  last fetch aborted on timeout.

Function
REQ-018 Two states, IDLE and WAIT; busy SHALL equal (state==WAIT).
REQ-019 IDLE, fetch=1, jmp_en=0: next edge -> WAIT, mem_req=1, mem_addr=pc, ir_valid=0, fetch_err=0, timeout counter=0.
REQ-020 IDLE, jmp_en=1, fetch=0: next edge pc=jmp_addr; state, ir, ir_valid unchanged.
REQ-021 IDLE, jmp_en=1 and fetch=1 same cycle: jump wins address -- pc=jmp_addr, mem_addr=jmp_addr, transition per REQ-019.
REQ-022 WAIT: mem_req and mem_addr SHALL remain stable until mem_ack or timeout.
REQ-023 WAIT, mem_ack=1: next edge ir=mem_rdata, pc=mem_addr+1 modulo 2^PC_W, ir_valid=1, mem_req=0, -> IDLE.
REQ-024 Minimum latency: fetch sampled at edge N, mem_req visible after N, mem_ack earliest in cycle after N, ir/ir_valid updated at edge N+2.
REQ-025 WAIT, no mem_ack: counter increments each cycle; when counter reaches TIMEOUT-1 without ack, next edge mem_req=0, fetch_err=1, -> IDLE; pc, ir unchanged, ir_valid stays 0.
REQ-026 mem_ack in the same cycle as the timeout condition: ack wins, REQ-023 applies, fetch_err=0.
REQ-027 fetch and jmp_en SHALL be ignored in WAIT (no pc change, no queued request).
REQ-028 mem_ack in IDLE SHALL be ignored; ir, pc unchanged.
REQ-029 pc=2^PC_W-1 fetched: pc wraps to 0, no flag.
REQ-030 fetch_err SHALL hold until the next accepted fetch or rst.
REQ-031 Back-to-back: fetch held high across ack edge -> new fetch accepted in the first IDLE cycle; no IDLE cycle skipped.

Reset
REQ-032 rst=1 at posedge: state=IDLE, pc=0, ir=0, ir_valid=0, mem_req=0, mem_addr=0, fetch_err=0, counter=0; overrides all other inputs.
REQ-033 rst during WAIT: mem_req=0 after that edge; a later mem_ack for the aborted request SHALL be ignored.

Verification
REQ-034 Reset, fetch pulse, mem_ack one cycle after mem_req with rdata=16'h3C21 -> ir=16'h3C21, opcode=5'b00111, pc=1, ir_valid=1 at edge N+2.
REQ-035 pc=8'h10, fetch and jmp_en with jmp_addr=8'h40 same cycle -> mem_addr=8'h40; after ack pc=8'h41.
REQ-036 Fetch with no ack, TIMEOUT=15 -> mem_req drops after 15 WAIT cycles, fetch_err=1, pc unchanged; next fetch clears fetch_err.
REQ-037 Load pc=8'hFF by jump, fetch, ack -> pc=8'h00, ir_valid=1.
REQ-038 jmp_en and fetch pulses during WAIT, ack after 3 cycles -> pc=mem_addr+1, no extra mem_req.
REQ-039 rst asserted in WAIT, stray mem_ack next cycle -> all outputs at reset values, ir=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the program counter and instruction register.
// It issues one read at a time to instruction memory. It waits for the
// memory acknowledge, or gives up after TIMEOUT cycles in WAIT.
module fetch_unit #(
  parameter int PC_W    = 8,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch,
  input  logic            jmp_en,
  input  logic [PC_W-1:0] jmp_addr,
  output logic            mem_req,
  output logic [PC_W-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [15:0]     mem_rdata,
  output logic [15:0]     ir,
  output logic [4:0]      opcode,
  output logic [PC_W-1:0] pc,
  output logic            ir_valid,
  output logic            busy,
  output logic            fetch_err
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  // The counter runs 0..TIMEOUT-1, so the WAIT phase lasts exactly TIMEOUT cycles.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t          state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] mem_addr_q;
  logic [15:0]     ir_q;
  logic            ir_valid_q;
  logic            mem_req_q;
  logic            fetch_err_q;
  logic [7:0]      cnt_q;

  logic [PC_W-1:0] fetch_addr_d;
  logic [PC_W-1:0] pc_inc_d;

  // A jump issued with a fetch redirects that same fetch. The next pc follows
  // the address that was actually read, and wraps naturally at 2^PC_W.
  always_comb begin
    fetch_addr_d = jmp_en ? jmp_addr : pc_q;
    pc_inc_d     = mem_addr_q + PC_W'(1);
  end

  // FSM: accept a fetch or jump in IDLE; in WAIT, finish on ack or abort on timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      mem_addr_q  <= '0;
      ir_q        <= '0;
      ir_valid_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      fetch_err_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fetch) begin
            state_q     <= WAIT;
            mem_req_q   <= 1'b1;
            mem_addr_q  <= fetch_addr_d;
            pc_q        <= fetch_addr_d;
            ir_valid_q  <= 1'b0;
            fetch_err_q <= 1'b0;
            cnt_q       <= '0;
          end else if (jmp_en) begin
            pc_q <= jmp_addr;
          end
        end
        WAIT: begin
          // fetch and jmp_en are deliberately not looked at here. An ack
          // wins over a timeout that falls in the same cycle.
          if (mem_ack) begin
            ir_q       <= mem_rdata;
            pc_q       <= pc_inc_d;
            ir_valid_q <= 1'b1;
            mem_req_q  <= 1'b0;
            state_q    <= IDLE;
          end else if (cnt_q == CNT_LAST) begin
            mem_req_q   <= 1'b0;
            fetch_err_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign ir        = ir_q;
  assign opcode    = ir_q[15:11];
  assign pc        = pc_q;
  assign ir_valid  = ir_valid_q;
  assign busy      = (state_q == WAIT);
  assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit. Expected values are computed by hand.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, fetch, jmp_en, mem_ack;
  logic [7:0]  jmp_addr;
  logic [15:0] mem_rdata;
  logic        mem_req, ir_valid, busy, fetch_err;
  logic [7:0]  mem_addr, pc;
  logic [15:0] ir;
  logic [4:0]  opcode;

  int n_pass  = 0;
  int n_total = 0;

  fetch_unit #(.PC_W(8), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .fetch(fetch), .jmp_en(jmp_en), .jmp_addr(jmp_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ir(ir), .opcode(opcode), .pc(pc), .ir_valid(ir_valid), .busy(busy),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  // Advance one clock edge; inputs change and outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch = 1'b1; jmp_en = 1'b1; jmp_addr = 8'h55; mem_ack = 1'b1; mem_rdata = 16'hFFFF;
    step(); step();
    rst = 1'b0; fetch = 1'b0; jmp_en = 1'b0; mem_ack = 1'b0;
    n_total++; if (pc !== 8'h00) $display("FAIL reset_pc got %h want 00", pc); else n_pass++;
    n_total++; if (ir !== 16'h0000) $display("FAIL reset_ir got %h want 0000", ir); else n_pass++;
    n_total++; if ({mem_req, ir_valid, busy, fetch_err} !== 4'b0000)
      $display("FAIL reset_flags got %b want 0000", {mem_req, ir_valid, busy, fetch_err}); else n_pass++;
    n_total++; if (mem_addr !== 8'h00) $display("FAIL reset_mem_addr got %h want 00", mem_addr); else n_pass++;
  endtask

  task automatic test_basic_fetch();
    fetch = 1'b1;
    step();  // edge N
    fetch = 1'b0;
    n_total++; if ({mem_req, busy, ir_valid} !== 3'b110 || mem_addr !== 8'h00)
      $display("FAIL basic_req got req/busy/vld=%b addr=%h want 110 addr=00", {mem_req, busy, ir_valid}, mem_addr); else n_pass++;
    step();  // edge N+1, memory not yet answering
    n_total++; if ({mem_req, busy} !== 2'b11) $display("FAIL basic_hold got %b want 11", {mem_req, busy}); else n_pass++;
    mem_ack = 1'b1; mem_rdata = 16'h3C21;
    step();  // edge N+2
    mem_ack = 1'b0;
    n_total++; if (ir !== 16'h3C21) $display("FAIL basic_ir got %h want 3c21", ir); else n_pass++;
    n_total++; if (opcode !== 5'b00111) $display("FAIL basic_opcode got %b want 00111", opcode); else n_pass++;
    n_total++; if (pc !== 8'h01) $display("FAIL basic_pc got %h want 01", pc); else n_pass++;
    n_total++; if ({ir_valid, mem_req, busy} !== 3'b100)
      $display("FAIL basic_done got vld/req/busy=%b want 100", {ir_valid, mem_req, busy}); else n_pass++;
  endtask

  task automatic test_jump_fetch();
    jmp_en = 1'b1; jmp_addr = 8'h10;
    step();
    jmp_en = 1'b0;
    n_total++; if (pc !== 8'h10 || busy !== 1'b0 || ir_valid !== 1'b1 || ir !== 16'h3C21)
      $display("FAIL jump_idle got pc=%h busy=%b vld=%b ir=%h want 10 0 1 3c21", pc, busy, ir_valid, ir); else n_pass++;
    fetch = 1'b1; jmp_en = 1'b1; jmp_addr = 8'h40;
    step();
    fetch = 1'b0; jmp_en = 1'b0;
    n_total++; if (mem_addr !== 8'h40 || mem_req !== 1'b1)
      $display("FAIL jumpfetch_addr got %h req=%b want 40 1", mem_addr, mem_req); else n_pass++;
    mem_ack = 1'b1; mem_rdata = 16'hA5F0;
    step();
    mem_ack = 1'b0;
    n_total++; if (pc !== 8'h41 || ir !== 16'hA5F0)
      $display("FAIL jumpfetch_pc got pc=%h ir=%h want 41 a5f0", pc, ir); else n_pass++;
  endtask

  task automatic test_ack_idle();
    mem_ack = 1'b1; mem_rdata = 16'hFFFF;
    step();
    mem_ack = 1'b0;
    n_total++; if (ir !== 16'hA5F0 || pc !== 8'h41 || busy !== 1'b0)
      $display("FAIL ack_idle got ir=%h pc=%h busy=%b want a5f0 41 0", ir, pc, busy); else n_pass++;
  endtask

  task automatic test_timeout();
    int cycles;
    fetch = 1'b1;
    step();
    fetch = 1'b0;
    cycles = 0;
    while (mem_req === 1'b1 && cycles < 40) begin
      step();
      cycles++;
    end
    n_total++; if (cycles !== 15) $display("FAIL timeout_cycles got %0d want 15", cycles); else n_pass++;
    n_total++; if (fetch_err !== 1'b1 || busy !== 1'b0 || ir_valid !== 1'b0)
      $display("FAIL timeout_flags got err=%b busy=%b vld=%b want 1 0 0", fetch_err, busy, ir_valid); else n_pass++;
    n_total++; if (pc !== 8'h41 || ir !== 16'hA5F0)
      $display("FAIL timeout_state got pc=%h ir=%h want 41 a5f0", pc, ir); else n_pass++;
    step();
    n_total++; if (fetch_err !== 1'b1) $display("FAIL timeout_hold got %b want 1", fetch_err); else n_pass++;
    fetch = 1'b1;
    step();
    fetch = 1'b0;
    n_total++; if (fetch_err !== 1'b0 || mem_addr !== 8'h41)
      $display("FAIL timeout_clear got err=%b addr=%h want 0 41", fetch_err, mem_addr); else n_pass++;
    mem_ack = 1'b1; mem_rdata = 16'h1234;
    step();
    mem_ack = 1'b0;
    n_total++; if (pc !== 8'h42 || ir !== 16'h1234)
      $display("FAIL timeout_refetch got pc=%h ir=%h want 42 1234", pc, ir); else n_pass++;
  endtask

  task automatic test_timeout_ack();
    fetch = 1'b1;
    step();
    fetch = 1'b0;
    for (int i = 0; i < 14; i++) step();
    n_total++; if (mem_req !== 1'b1) $display("FAIL tack_still_wait got %b want 1", mem_req); else n_pass++;
    mem_ack = 1'b1; mem_rdata = 16'h5555;
    step();
    mem_ack = 1'b0;
    n_total++; if (fetch_err !== 1'b0 || ir_valid !== 1'b1 || ir !== 16'h5555 || pc !== 8'h43)
      $display("FAIL tack_result got err=%b vld=%b ir=%h pc=%h want 0 1 5555 43", fetch_err, ir_valid, ir, pc); else n_pass++;
  endtask

  task automatic test_wrap();
    jmp_en = 1'b1; jmp_addr = 8'hFF;
    step();
    jmp_en = 1'b0; fetch = 1'b1;
    step();
    fetch = 1'b0;
    n_total++; if (mem_addr !== 8'hFF) $display("FAIL wrap_addr got %h want ff", mem_addr); else n_pass++;
    mem_ack = 1'b1; mem_rdata = 16'h0800;
    step();
    mem_ack = 1'b0;
    n_total++; if (pc !== 8'h00 || ir_valid !== 1'b1 || fetch_err !== 1'b0)
      $display("FAIL wrap_pc got pc=%h vld=%b err=%b want 00 1 0", pc, ir_valid, fetch_err); else n_pass++;
  endtask

  task automatic test_wait_ignore();
    fetch = 1'b1;
    step();
    fetch = 1'b0;
    jmp_en = 1'b1; jmp_addr = 8'h77; fetch = 1'b1;
    step();
    jmp_en = 1'b0; fetch = 1'b0;
    n_total++; if (pc !== 8'h00 || mem_addr !== 8'h00 || mem_req !== 1'b1)
      $display("FAIL waitign_hold got pc=%h addr=%h req=%b want 00 00 1", pc, mem_addr, mem_req); else n_pass++;
    step();
    mem_ack = 1'b1; mem_rdata = 16'h2222;
    step();
    mem_ack = 1'b0;
    n_total++; if (pc !== 8'h01 || mem_req !== 1'b0)
      $display("FAIL waitign_ack got pc=%h req=%b want 01 0", pc, mem_req); else n_pass++;
    step();
    n_total++; if (mem_req !== 1'b0 || busy !== 1'b0)
      $display("FAIL waitign_noqueue got req=%b busy=%b want 0 0", mem_req, busy); else n_pass++;
  endtask

  task automatic test_back_to_back();
    fetch = 1'b1;
    step();
    mem_ack = 1'b1; mem_rdata = 16'h3333;
    step();
    mem_ack = 1'b0;
    n_total++; if (busy !== 1'b0 || pc !== 8'h02 || ir !== 16'h3333)
      $display("FAIL b2b_first got busy=%b pc=%h ir=%h want 0 02 3333", busy, pc, ir); else n_pass++;
    step();
    fetch = 1'b0;
    n_total++; if (mem_req !== 1'b1 || mem_addr !== 8'h02)
      $display("FAIL b2b_second_req got req=%b addr=%h want 1 02", mem_req, mem_addr); else n_pass++;
    mem_ack = 1'b1; mem_rdata = 16'h4444;
    step();
    mem_ack = 1'b0;
    n_total++; if (pc !== 8'h03 || ir !== 16'h4444)
      $display("FAIL b2b_second got pc=%h ir=%h want 03 4444", pc, ir); else n_pass++;
  endtask

  task automatic test_rst_wait();
    fetch = 1'b1;
    step();
    fetch = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_total++; if (mem_req !== 1'b0) $display("FAIL rstwait_req got %b want 0", mem_req); else n_pass++;
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    step();
    mem_ack = 1'b0;
    n_total++; if (ir !== 16'h0000 || pc !== 8'h00 || mem_addr !== 8'h00)
      $display("FAIL rstwait_data got ir=%h pc=%h addr=%h want 0000 00 00", ir, pc, mem_addr); else n_pass++;
    n_total++; if ({mem_req, ir_valid, busy, fetch_err} !== 4'b0000)
      $display("FAIL rstwait_flags got %b want 0000", {mem_req, ir_valid, busy, fetch_err}); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; fetch = 1'b0; jmp_en = 1'b0; jmp_addr = 8'h00; mem_ack = 1'b0; mem_rdata = 16'h0000;
    #2;
    test_reset();
    test_basic_fetch();
    test_jump_fetch();
    test_ack_idle();
    test_timeout();
    test_timeout_ack();
    test_wrap();
    test_wait_ignore();
    test_back_to_back();
    test_rst_wait();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
